// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file write-back path.
package regfile_pkg;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam logic [4:0] REG_LINK   = 5'd31;
    localparam int         NUM_WB_SRC = 3;

    localparam logic [1:0] SRC_ALU  = 2'd0;
    localparam logic [1:0] SRC_MEM  = 2'd1;
    localparam logic [1:0] SRC_LINK = 2'd2;

    typedef struct packed {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
    } slot_t;

    // Slot index k positions after last, wrapping over the sources.
    function automatic logic [1:0] rr_next(input logic [1:0] last,
                                           input int unsigned k);
        return 2'((32'(last) + k) % NUM_WB_SRC);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry write-back holding buffer; writes to register 0 are dropped.
module wb_slot
    import regfile_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [4:0]  i_addr,
    input  logic [31:0] i_data,
    input  logic        i_drain,
    output slot_t       o_slot
);

    slot_t r_slot;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_slot <= '0;
        end else if (i_accept) begin
            r_slot.valid <= (i_addr != REG_ZERO);
            r_slot.addr  <= i_addr;
            r_slot.data  <= i_data;
        end else if (i_drain) begin
            r_slot.valid <= 1'b0;
        end
    end

    assign o_slot = r_slot;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file single write port,
// with a pending-write scoreboard feeding decode-stage read stalls.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_SRC = NUM_WB_SRC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    input  logic        link_valid,
    output logic        link_ready,
    input  logic [31:0] link_data,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic        stall1,
    output logic        stall2,
    output logic [31:0] pending,
    output logic        busy
);

    slot_t               w_slot    [NUM_SRC];
    logic [4:0]          w_addr_in [NUM_SRC];
    logic [31:0]         w_data_in [NUM_SRC];
    logic [NUM_SRC-1:0]  w_req;
    logic [NUM_SRC-1:0]  w_ready;
    logic [NUM_SRC-1:0]  w_grant;
    logic [NUM_SRC-1:0]  w_conf;
    logic [NUM_SRC-1:0]  w_occ;
    logic [1:0]          w_gidx;
    logic                w_found;
    logic [31:0]         w_pend;

    logic [1:0]          r_last;
    logic                r_we;
    logic [4:0]          r_waddr;
    logic [31:0]         r_wdata;

    assign w_req        = {link_valid, mem_valid, alu_valid};
    assign w_addr_in[0] = alu_addr;
    assign w_addr_in[1] = mem_addr;
    assign w_addr_in[2] = REG_LINK;
    assign w_data_in[0] = alu_data;
    assign w_data_in[1] = mem_data;
    assign w_data_in[2] = link_data;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
        assign w_occ[g] = w_slot[g].valid;
        wb_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .i_accept (w_req[g] & w_ready[g]),
            .i_addr   (w_addr_in[g]),
            .i_data   (w_data_in[g]),
            .i_drain  (w_grant[g]),
            .o_slot   (w_slot[g])
        );
    end

    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!w_found && w_occ[rr_next(r_last, k)]) begin
                w_found = 1'b1;
                w_gidx  = rr_next(r_last, k);
            end
        end
        w_grant = w_found ? (NUM_SRC'(1) << w_gidx) : '0;
    end

    // Blocking on a same-destination slot keeps per-register write order.
    always_comb begin
        w_conf  = '0;
        w_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j != i && w_slot[j].valid &&
                    w_slot[j].addr == w_addr_in[i]) begin
                    w_conf[i] = 1'b1;
                end
            end
            w_ready[i] = reset & (~w_slot[i].valid | w_grant[i])
                       & ~w_conf[i];
        end
    end

    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_slot[i].valid) begin
                w_pend[w_slot[i].addr] = 1'b1;
            end
        end
        w_pend[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_last  <= SRC_LINK;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_found) begin
            r_last  <= w_gidx;
            r_we    <= 1'b1;
            r_waddr <= w_slot[w_gidx].addr;
            r_wdata <= w_slot[w_gidx].data;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign alu_ready  = w_ready[SRC_ALU];
    assign mem_ready  = w_ready[SRC_MEM];
    assign link_ready = w_ready[SRC_LINK];
    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign pending    = w_pend;
    assign stall1     = w_pend[raddr1];
    assign stall2     = w_pend[raddr2];
    assign busy       = |w_occ;

endmodule
